// File: rtl/sound_event_arbiter.sv
// sound_event_arbiter: latches game sound events and grants the single tone generator by priority.
// Ports: clk, resetN (async active-low) | enable (run/freeze), tick (timebase strobe),
//        req[N_SRC] (event pulses) | sound_on (tone gate), sound_id (playing source),
//        grant[N_SRC] (one-hot start pulse), busy (PLAY or GAP).
module sound_event_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DUR_TICKS = 200,
    parameter int GAP_TICKS = 20
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     enable,
    input  logic                     tick,
    input  logic [N_SRC-1:0]         req,
    output logic                     sound_on,
    output logic [$clog2(N_SRC)-1:0] sound_id,
    output logic [N_SRC-1:0]         grant,
    output logic                     busy
);
    localparam int IW = $clog2(N_SRC);
    localparam logic [9:0] DUR_T = 10'(DUR_TICKS);
    localparam logic [9:0] GAP_T = 10'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t state, state_n;
    logic [N_SRC-1:0] pending, pending_n, grant_n;
    logic [9:0] timer, timer_n;
    logic [IW-1:0] sel, sound_id_n;
    logic start, sound_on_n;

    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (pending[i]) sel = IW'(i);
    end

    // A start (fresh or preempting) beats timer expiry and ignores a coincident tick.
    assign start = enable && (|pending) && (state == IDLE || (state == PLAY && sel < sound_id));

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        sound_id_n = sound_id;
        grant_n    = '0;
        if (start) begin
            state_n    = PLAY;
            timer_n    = DUR_T;
            sound_id_n = sel;
            grant_n    = N_SRC'(1) << sel;
        end else if (enable && tick && state != IDLE) begin
            if (timer > 10'd1) timer_n = timer - 10'd1;
            else if (state == PLAY && GAP_TICKS != 0) begin
                state_n = GAP;
                timer_n = GAP_T;
            end else begin
                state_n = IDLE;
                timer_n = '0;
            end
        end
        // A request arriving in its own grant cycle re-arms the source.
        pending_n  = (pending & ~grant_n) | req;
        sound_on_n = enable && state_n == PLAY;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            pending  <= '0;
            timer    <= '0;
            sound_on <= 1'b0;
            sound_id <= '0;
            grant    <= '0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            timer    <= timer_n;
            sound_on <= sound_on_n;
            sound_id <= sound_id_n;
            grant    <= grant_n;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb_sound_event_arbiter: directed bench for sound_event_arbiter with a cycle model and literal checks.
module tb_sound_event_arbiter;
    logic clk = 1'b0, resetN = 1'b0, enable = 1'b1, tick = 1'b0;
    logic [3:0] req = '0;
    logic sound_on_a, busy_a, sound_on_b, busy_b;
    logic [1:0] sound_id_a, sound_id_b;
    logic [3:0] grant_a, grant_b;
    int total = 0, bad = 0;
    int tcnt = 0;

    // Instance a: DUR=3, GAP=2. Instance b: DUR=3, GAP=0. Both see the same stimulus.
    sound_event_arbiter #(.N_SRC(4), .DUR_TICKS(3), .GAP_TICKS(2)) dut_a (
        .clk(clk), .resetN(resetN), .enable(enable), .tick(tick), .req(req),
        .sound_on(sound_on_a), .sound_id(sound_id_a), .grant(grant_a), .busy(busy_a));
    sound_event_arbiter #(.N_SRC(4), .DUR_TICKS(3), .GAP_TICKS(0)) dut_b (
        .clk(clk), .resetN(resetN), .enable(enable), .tick(tick), .req(req),
        .sound_on(sound_on_b), .sound_id(sound_id_b), .grant(grant_b), .busy(busy_b));

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        tick = (tcnt == 3);
        tcnt = (tcnt + 1) % 4;
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 4;
    endfunction

    // Model: phase 0=silent, 1=playing, 2=gap; cnt counts ticks spent in the current phase.
    int dur_v = 3;
    int gap_v[2] = '{2, 0};
    int m_phase[2], m_cnt[2], m_id[2];
    logic [3:0] m_pend[2], m_grant[2];
    logic m_on[2];

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] = 0; m_cnt[k] = 0; m_id[k] = 0;
                m_pend[k] = '0; m_grant[k] = '0; m_on[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int s;
                m_grant[k] = '0;
                if (enable) begin
                    s = lowest(m_pend[k]);
                    if (s < 4 && (m_phase[k] == 0 || (m_phase[k] == 1 && s < m_id[k]))) begin
                        m_phase[k] = 1; m_cnt[k] = 0; m_id[k] = s;
                        m_grant[k][s] = 1'b1;
                        m_pend[k][s] = 1'b0;
                    end else if (tick && m_phase[k] != 0) begin
                        m_cnt[k]++;
                        if (m_phase[k] == 1 && m_cnt[k] == dur_v) begin
                            m_cnt[k] = 0;
                            m_phase[k] = (gap_v[k] > 0) ? 2 : 0;
                        end else if (m_phase[k] == 2 && m_cnt[k] == gap_v[k]) begin
                            m_cnt[k] = 0;
                            m_phase[k] = 0;
                        end
                    end
                end
                m_pend[k] = m_pend[k] | req;
                m_on[k] = enable && m_phase[k] == 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("a_sound_on", sound_on_a, m_on[0]);
        chk("a_sound_id", sound_id_a, m_id[0]);
        chk("a_grant", grant_a, m_grant[0]);
        chk("a_busy", busy_a, m_phase[0] != 0);
        chk("b_sound_on", sound_on_b, m_on[1]);
        chk("b_sound_id", sound_id_b, m_id[1]);
        chk("b_grant", grant_b, m_grant[1]);
        chk("b_busy", busy_b, m_phase[1] != 0);
    end

    int gseq[64];
    int ng = 0;
    always @(negedge clk) begin
        if (grant_a != 0) begin
            gseq[ng % 64] = lowest(grant_a);
            ng++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) break;
        end
        chk("wait_idle", i < 300, 1);
    endtask

    task automatic ticks_until_silent(input string name, input int exp);
        int nt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (tick) nt++;
            @(negedge clk);
            if (!sound_on_a) break;
        end
        chk(name, nt, exp);
    endtask

    initial begin
        int nt, base, n3, i;
        repeat (3) cyc();
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_sound_on", sound_on_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_grant", grant_a, 0);
        chk("rst_sound_id", sound_id_a, 0);

        // 1: single request, duration and gap
        cyc(); req = 4'b0100;
        cyc(); req = '0;
        @(negedge clk);
        chk("t1_no_grant_yet", grant_a, 0);
        cyc();
        @(negedge clk);
        chk("t1_grant", grant_a, 4'b0100);
        chk("t1_sound_on", sound_on_a, 1);
        chk("t1_sound_id", sound_id_a, 2);
        ticks_until_silent("t1_play_ticks", 3);
        nt = 0;
        for (i = 0; i < 100; i++) begin
            @(posedge clk);
            if (tick) nt++;
            @(negedge clk);
            if (!busy_a) break;
        end
        chk("t1_gap_ticks", nt, 2);

        // 2: preemption by a higher-priority source
        wait_idle();
        cyc(); req = 4'b1000;
        cyc(); req = '0;
        repeat (4) cyc();
        req = 4'b0010;
        cyc(); req = '0;
        cyc();
        @(negedge clk);
        chk("t2_grant", grant_a, 4'b0010);
        chk("t2_sound_id", sound_id_a, 1);
        ticks_until_silent("t2_reload_ticks", 3);
        n3 = 0;
        repeat (40) begin
            @(negedge clk);
            if (grant_a[3]) n3++;
        end
        chk("t2_no_replay_3", n3, 0);

        // 3: repeat of the playing source outranks a lower-priority waiter
        wait_idle();
        base = ng;
        cyc(); req = 4'b0010;
        cyc(); req = '0;
        repeat (4) cyc();
        req = 4'b1000;
        cyc(); req = 4'b0010;
        cyc(); req = '0;
        repeat (120) cyc();
        chk("t3_grant_count", ng - base, 3);
        chk("t3_first", gseq[base % 64], 1);
        chk("t3_second", gseq[(base + 1) % 64], 1);
        chk("t3_third", gseq[(base + 2) % 64], 3);

        // 4: pause mid-play, remaining time honoured, paused request waits
        wait_idle();
        cyc(); req = 4'b0001;
        cyc(); req = '0;
        cyc();
        for (i = 0; i < 10; i++) begin
            @(posedge clk);
            if (tick) break;
        end
        #2 enable = 1'b0;
        base = ng;
        repeat (20) cyc();
        req = 4'b0001;
        cyc(); req = '0;
        repeat (28) cyc();
        @(negedge clk);
        chk("t4_muted", sound_on_a, 0);
        chk("t4_busy_held", busy_a, 1);
        chk("t4_no_grant_paused", ng - base, 0);
        cyc(); enable = 1'b1;
        ticks_until_silent("t4_remaining_ticks", 2);
        repeat (60) cyc();
        chk("t4_replay_count", ng - base, 1);
        chk("t4_replay_src", gseq[base % 64], 0);

        // 5: async reset mid-play with pending requests
        wait_idle();
        cyc(); req = 4'b0010;
        cyc(); req = '0;
        repeat (3) cyc();
        req = 4'b1100;
        cyc(); req = '0;
        cyc(); resetN = 1'b0;
        @(negedge clk);
        chk("t5_sound_on", sound_on_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_sound_id", sound_id_a, 0);
        chk("t5_grant", grant_a, 0);
        cyc(); resetN = 1'b1;
        base = ng;
        repeat (40) cyc();
        chk("t5_no_grant_after", ng - base, 0);

        // 6: GAP_TICKS=0, back-to-back with one silent clk
        wait_idle();
        cyc(); req = 4'b0011;
        cyc(); req = '0;
        cyc();
        @(negedge clk);
        chk("t6_first_grant", grant_b, 4'b0001);
        chk("t6_first_on", sound_on_b, 1);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!sound_on_b) break;
        end
        chk("t6_silent_once", grant_b, 0);
        @(negedge clk);
        chk("t6_second_grant", grant_b, 4'b0010);
        chk("t6_second_on", sound_on_b, 1);

        wait_idle();
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
